pipe_delay_line: RTL and testbench

- Parametrised multi-bit, multi-stage successor to the single-bit DFF.
- Delays a valid/data stream (e.g. hsync/vsync/blank/pixel bundle) by a runtime-selectable number of clock-enabled cycles, so timing signals align with the VGA pixel pipeline latency.
- Adds clock enable, flush, a runtime delay select, and a settled indicator.
- Sits between the timing generator and the output register stage.

---
 rtl/vga_pipe_pkg.sv | 22 ++
 rtl/pipe_stage.sv | 52 +++++
 rtl/pipe_delay_line.sv | 110 +++++++++++
 tb/tb_pipe_delay_line.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/vga_pipe_pkg.sv
// Shared constants and helpers for the VGA pixel-pipeline blocks.
package vga_pipe_pkg;

  localparam int unsigned DefWidth    = 8;
  localparam int unsigned DefMaxDepth = 4;

  // Bit positions of the timing signals inside a VGA timing bundle.
  localparam int unsigned HsBit    = 0;
  localparam int unsigned VsBit    = 1;
  localparam int unsigned BlankBit = 2;

  // Ceiling log2; returns at least 1 for n >= 2.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 1; i < n; i = i << 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One {valid, data} register stage of the delay line.
// PIPE_DELAY_RESET_DATA_EN: when defined, rst_i also clears the data register.
module pipe_stage #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ce_i,
  input  logic             clr_i,
  input  logic             v_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             v_o,
  output logic [WIDTH-1:0] d_o
);

  logic             v_q;
  logic [WIDTH-1:0] d_q;

  // Valid bit: cleared by reset/flush/delay change, otherwise advances on ce.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      v_q <= 1'b0;
    end else if (ce_i) begin
      v_q <= v_i;
    end
  end

`ifdef PIPE_DELAY_RESET_DATA_EN
  // Data register with reset; a flush leaves data untouched.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      d_q <= '0;
    end else if (ce_i && !clr_i) begin
      d_q <= d_i;
    end
  end
`else
  logic unused_rst;
  assign unused_rst = rst_i;

  // Data register without reset so the chain can map onto shift-register primitives.
  always_ff @(posedge clk_i) begin
    if (ce_i && !clr_i) begin
      d_q <= d_i;
    end
  end
`endif

  assign v_o = v_q;
  assign d_o = d_q;

endmodule

// File: rtl/pipe_delay_line.sv
// Runtime-selectable valid/data delay line with clock enable, flush and settled flag.
// PIPE_DELAY_RESET_DATA_EN: when defined, reset also zeroes every stage's data.
module pipe_delay_line
  import vga_pipe_pkg::*;
#(
  parameter int unsigned WIDTH     = DefWidth,
  parameter int unsigned MAX_DEPTH = DefMaxDepth,
  localparam int unsigned DLY_W    = clog2(MAX_DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ce_i,
  input  logic             flush_i,
  input  logic [DLY_W-1:0] dly_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             settled_o
);

  logic [DLY_W-1:0] eff;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [DLY_W-1:0] cnt_q, cnt_d;
  logic             settled_q, settled_d;
  logic             stage_clr;

  logic             v_in [MAX_DEPTH];
  logic [WIDTH-1:0] d_in [MAX_DEPTH];
  logic             v_s  [MAX_DEPTH];
  logic [WIDTH-1:0] d_s  [MAX_DEPTH];

  // Clamp the requested delay so out-of-range values saturate instead of wrapping.
  always_comb begin
    eff = dly_i;
    if (32'(dly_i) > MAX_DEPTH) begin
      eff = DLY_W'(MAX_DEPTH);
    end
  end

  // A delay change behaves exactly like a flush.
  assign stage_clr = rst_i | flush_i | (eff != dly_q);

  // Next-state for delay register and settle counter.
  always_comb begin
    dly_d = dly_q;
    cnt_d = cnt_q;
    if (stage_clr) begin
      dly_d = eff;
      cnt_d = '0;
    end else if (ce_i && (cnt_q < dly_q)) begin
      cnt_d = cnt_q + DLY_W'(1);
    end
    settled_d = (cnt_d == dly_d);
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dly_q     <= eff;
      cnt_q     <= '0;
      settled_q <= (eff == '0);
    end else begin
      dly_q     <= dly_d;
      cnt_q     <= cnt_d;
      settled_q <= settled_d;
    end
  end

  for (genvar k = 0; k < MAX_DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign v_in[k] = in_valid_i;
      assign d_in[k] = in_data_i;
    end else begin : g_chain
      assign v_in[k] = v_s[k-1];
      assign d_in[k] = d_s[k-1];
    end

    pipe_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .ce_i  (ce_i),
      .clr_i (stage_clr),
      .v_i   (v_in[k]),
      .d_i   (d_in[k]),
      .v_o   (v_s[k]),
      .d_o   (d_s[k])
    );
  end

  // Output tap: zero delay passes the input straight through; reset masks valid.
  always_comb begin
    out_valid_o = in_valid_i;
    out_data_o  = in_data_i;
    for (int k = 0; k < MAX_DEPTH; k++) begin
      if (eff == DLY_W'(k + 1)) begin
        out_valid_o = v_s[k];
        out_data_o  = d_s[k];
      end
    end
    if (rst_i) begin
      out_valid_o = 1'b0;
    end
  end

  assign settled_o = settled_q;

endmodule

// File: tb/tb_pipe_delay_line.sv
// Directed self-checking bench for pipe_delay_line (WIDTH=8, MAX_DEPTH=4).
module tb_pipe_delay_line;

  localparam int unsigned Width    = 8;
  localparam int unsigned MaxDepth = 4;
  localparam int unsigned DlyW     = 3;

  logic            clk;
  logic            rst;
  logic            ce;
  logic            flush;
  logic [DlyW-1:0] dly;
  logic            in_valid;
  logic [Width-1:0] in_data;
  logic            out_valid;
  logic [Width-1:0] out_data;
  logic            settled;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_delay_line #(
    .WIDTH    (Width),
    .MAX_DEPTH(MaxDepth)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .ce_i       (ce),
    .flush_i    (flush),
    .dly_i      (dly),
    .in_valid_i (in_valid),
    .in_data_i  (in_data),
    .out_valid_o(out_valid),
    .out_data_o (out_data),
    .settled_o  (settled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs, then advance one clock edge and settle 1 time unit past it.
  task automatic cyc(input logic c, input logic f, input logic v, input logic [7:0] d);
    ce       = c;
    flush    = f;
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [DlyW-1:0] dl);
    rst   = 1'b1;
    dly   = dl;
    ce    = 1'b0;
    flush = 1'b0;
    #1;
    check_eq("rst_valid_forced", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b0; ce = 1'b0; flush = 1'b0; dly = '0; in_valid = 1'b0; in_data = '0;
    @(posedge clk);
    #1;

    // dly=3 stream
    do_reset(3'd3);
    check_eq("d3_reset_valid", {31'd0, out_valid}, 32'd0);
    check_eq("d3_reset_settled", {31'd0, settled}, 32'd0);
    for (int e = 1; e <= 6; e++) begin
      cyc(1'b1, 1'b0, 1'b1, 8'(e));
      check_eq($sformatf("d3_valid_e%0d", e), {31'd0, out_valid}, (e >= 3) ? 32'd1 : 32'd0);
      check_eq($sformatf("d3_settled_e%0d", e), {31'd0, settled}, (e >= 3) ? 32'd1 : 32'd0);
      if (e >= 3) check_eq($sformatf("d3_data_e%0d", e), {24'd0, out_data}, 32'(e - 2));
    end

    // dly=0 pass-through
    do_reset(3'd0);
    check_eq("d0_settled", {31'd0, settled}, 32'd1);
    ce = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
    #1;
    check_eq("d0_data", {24'd0, out_data}, 32'hA5);
    check_eq("d0_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    #1;
    check_eq("d0_valid_low", {31'd0, out_valid}, 32'd0);

    // dly=2 with ce toggling
    do_reset(3'd2);
    cyc(1'b1, 1'b0, 1'b1, 8'h10);
    check_eq("ce_a_valid", {31'd0, out_valid}, 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 8'h11);
    check_eq("ce_b_valid", {31'd0, out_valid}, 32'd0);
    check_eq("ce_b_settled", {31'd0, settled}, 32'd0);
    cyc(1'b1, 1'b0, 1'b1, 8'h11);
    check_eq("ce_c_valid", {31'd0, out_valid}, 32'd1);
    check_eq("ce_c_data", {24'd0, out_data}, 32'h10);
    check_eq("ce_c_settled", {31'd0, settled}, 32'd1);
    cyc(1'b0, 1'b0, 1'b1, 8'h12);
    check_eq("ce_d_hold_valid", {31'd0, out_valid}, 32'd1);
    check_eq("ce_d_hold_data", {24'd0, out_data}, 32'h10);
    cyc(1'b1, 1'b0, 1'b1, 8'h12);
    check_eq("ce_e_data", {24'd0, out_data}, 32'h11);

    // dly=4 stream, then flush
    do_reset(3'd4);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b1, 8'(8'h20 + i));
    check_eq("d4_pre_valid", {31'd0, out_valid}, 32'd1);
    check_eq("d4_pre_data", {24'd0, out_data}, 32'h22);
    check_eq("d4_pre_settled", {31'd0, settled}, 32'd1);
    cyc(1'b1, 1'b1, 1'b1, 8'h26);
    check_eq("fl_valid", {31'd0, out_valid}, 32'd0);
    check_eq("fl_settled", {31'd0, settled}, 32'd0);
    for (int j = 1; j <= 5; j++) begin
      cyc(1'b1, 1'b0, 1'b1, 8'(8'h26 + j));
      check_eq($sformatf("fl_valid_j%0d", j), {31'd0, out_valid}, (j >= 4) ? 32'd1 : 32'd0);
      check_eq($sformatf("fl_settled_j%0d", j), {31'd0, settled}, (j >= 4) ? 32'd1 : 32'd0);
      if (j >= 4) check_eq($sformatf("fl_data_j%0d", j), {24'd0, out_data}, 32'(8'h26 + j - 3));
    end

    // delay change 4->2 (discards change-edge sample)
    dly = 3'd2;
    cyc(1'b1, 1'b0, 1'b1, 8'h30);
    check_eq("ch2_valid", {31'd0, out_valid}, 32'd0);
    check_eq("ch2_settled", {31'd0, settled}, 32'd0);
    cyc(1'b1, 1'b0, 1'b1, 8'h31);
    check_eq("ch2_valid_1", {31'd0, out_valid}, 32'd0);
    cyc(1'b1, 1'b0, 1'b1, 8'h32);
    check_eq("ch2_valid_2", {31'd0, out_valid}, 32'd1);
    check_eq("ch2_data_2", {24'd0, out_data}, 32'h31);
    cyc(1'b1, 1'b0, 1'b1, 8'h33);
    check_eq("ch2_data_3", {24'd0, out_data}, 32'h32);

    // delay change 2->7, clamped to 4
    dly = 3'd7;
    #1;
    check_eq("ch7_tap4_pre", {31'd0, out_valid}, 32'd0);
    cyc(1'b1, 1'b0, 1'b1, 8'h40);
    check_eq("ch7_valid", {31'd0, out_valid}, 32'd0);
    for (int j = 1; j <= 5; j++) begin
      cyc(1'b1, 1'b0, 1'b1, 8'(8'h40 + j));
      check_eq($sformatf("ch7_valid_j%0d", j), {31'd0, out_valid}, (j >= 4) ? 32'd1 : 32'd0);
      check_eq($sformatf("ch7_settled_j%0d", j), {31'd0, settled}, (j >= 4) ? 32'd1 : 32'd0);
      if (j >= 4) check_eq($sformatf("ch7_data_j%0d", j), {24'd0, out_data}, 32'(8'h40 + j - 3));
    end

    // fill with 0xFF at dly=4, then reset
    dly = 3'd4;
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b1, 8'hFF);
    check_eq("ff_valid", {31'd0, out_valid}, 32'd1);
    check_eq("ff_data", {24'd0, out_data}, 32'hFF);
    do_reset(3'd4);
    check_eq("ff_rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("ff_rst_settled", {31'd0, settled}, 32'd0);
`ifdef PIPE_DELAY_RESET_DATA_EN
    check_eq("ff_rst_data", {24'd0, out_data}, 32'h00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
